// File: rtl/text_buffer_ctrl.sv
// rtl/text_buffer_ctrl.sv - character-cell text buffer with fetch/write/clear/scroll arbitration
// Display fetch owns the port on cell-aligned pixels; writes and the sequencer share the rest.
module text_buffer_ctrl #(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int CELL_W = 8,
    parameter int CELL_H = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       video_on,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [6:0] wr_col,
    input  logic [4:0] wr_row,
    input  logic [7:0] wr_char,
    output logic       wr_err,
    input  logic       clear_req,
    input  logic       scroll_req,
    output logic       busy,
    output logic [7:0] ascii_char
);
    localparam int DEPTH = COLS * ROWS;
    localparam int AW    = $clog2(DEPTH);
    localparam int XB    = $clog2(CELL_W);
    localparam int YB    = $clog2(CELL_H);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] LAST_ROW  = AW'((ROWS - 1) * COLS);
    localparam logic [AW-1:0] COLS_A    = AW'(COLS);
    localparam logic [7:0]    SPACE     = 8'h20;

    typedef enum logic [2:0] {IDLE, CLEAR, SCR_RD, SCR_WR, SCR_FILL} state_t;

    state_t          r_state;
    logic [AW-1:0]   r_ptr;
    logic [7:0]      r_hold;
    logic [7:0]      r_mem [0:DEPTH-1];

    logic            w_fetch;
    logic [9:0]      w_fcol;
    logic [9:0]      w_frow;
    logic [AW-1:0]   w_faddr;
    logic [AW-1:0]   w_cpu_addr;
    logic            w_in_range;
    logic            w_wr_acc;
    logic            w_we;
    logic [AW-1:0]   w_waddr;
    logic [7:0]      w_wdata;

    assign w_fetch    = video_on && (x[XB-1:0] == '0);
    assign w_fcol     = x >> XB;
    assign w_frow     = y >> YB;
    assign w_faddr    = AW'(w_frow) * COLS_A + AW'(w_fcol);
    assign w_cpu_addr = AW'(wr_row) * COLS_A + AW'(wr_col);
    assign w_in_range = (32'(wr_col) < COLS) && (32'(wr_row) < ROWS);

    assign wr_ready = !reset && (r_state == IDLE) && !w_fetch && !clear_req && !scroll_req;
    assign w_wr_acc = wr_valid && wr_ready;

    // Single write port: CPU writes only happen in IDLE, so they never collide with the sequencer.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_ptr;
        w_wdata = SPACE;
        if (!reset && !w_fetch) begin
            case (r_state)
                IDLE: begin
                    if (w_wr_acc && w_in_range) begin
                        w_we    = 1'b1;
                        w_waddr = w_cpu_addr;
                        w_wdata = wr_char;
                    end
                end
                CLEAR, SCR_FILL: w_we = 1'b1;
                SCR_WR: begin
                    w_we    = 1'b1;
                    w_wdata = r_hold;
                end
                default: w_we = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_hold     <= 8'h00;
            ascii_char <= 8'h00;
            busy       <= 1'b0;
            wr_err     <= 1'b0;
        end else begin
            wr_err <= w_wr_acc && !w_in_range;
            if (w_fetch) ascii_char <= r_mem[w_faddr];
            case (r_state)
                IDLE: begin
                    r_ptr <= '0;
                    if (clear_req) begin
                        r_state <= CLEAR;
                        busy    <= 1'b1;
                    end else if (scroll_req) begin
                        r_state <= SCR_RD;
                        busy    <= 1'b1;
                    end
                end
                CLEAR, SCR_FILL: begin
                    if (!w_fetch) begin
                        if (r_ptr == LAST_ADDR) begin
                            r_state <= IDLE;
                            r_ptr   <= '0;
                            busy    <= 1'b0;
                        end else begin
                            r_ptr <= r_ptr + 1'b1;
                        end
                    end
                end
                SCR_RD: begin
                    if (!w_fetch) begin
                        r_hold  <= r_mem[r_ptr + COLS_A];
                        r_state <= SCR_WR;
                    end
                end
                SCR_WR: begin
                    if (!w_fetch) begin
                        r_ptr   <= r_ptr + 1'b1;
                        r_state <= (r_ptr + 1'b1 == LAST_ROW) ? SCR_FILL : SCR_RD;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_text_buffer_ctrl.sv
// tb/tb_text_buffer_ctrl.sv - directed self-checking bench for text_buffer_ctrl
module tb_text_buffer_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       video_on;
    logic [9:0] x;
    logic [9:0] y;
    logic       wr_valid;
    logic       wr_ready;
    logic [6:0] wr_col;
    logic [4:0] wr_row;
    logic [7:0] wr_char;
    logic       wr_err;
    logic       clear_req;
    logic       scroll_req;
    logic       busy;
    logic [7:0] ascii_char;

    int n_cmp = 0;
    int n_bad = 0;

    text_buffer_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .video_on   (video_on),
        .x          (x),
        .y          (y),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_col     (wr_col),
        .wr_row     (wr_row),
        .wr_char    (wr_char),
        .wr_err     (wr_err),
        .clear_req  (clear_req),
        .scroll_req (scroll_req),
        .busy       (busy),
        .ascii_char (ascii_char)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input int col, input int row, output logic [7:0] d);
        video_on = 1'b1;
        x = 10'(col * 8);
        y = 10'(row * 16);
        tick();
        video_on = 1'b0;
        d = ascii_char;
    endtask

    task automatic wr(input int col, input int row, input logic [7:0] ch);
        video_on = 1'b0;
        wr_valid = 1'b1;
        wr_col   = 7'(col);
        wr_row   = 5'(row);
        wr_char  = ch;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 10000) begin
            tick();
            n++;
        end
    endtask

    initial begin
        logic [7:0] d;
        int         n;

        reset = 1'b1; video_on = 1'b0; x = '0; y = '0;
        wr_valid = 1'b0; wr_col = '0; wr_row = '0; wr_char = '0;
        clear_req = 1'b0; scroll_req = 1'b0;
        tick(); tick();
        chk("rst_ascii", 16'(ascii_char), 16'h00);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_wr_err", 16'(wr_err), 16'h0);
        chk("rst_wr_ready", 16'(wr_ready), 16'h0);
        reset = 1'b0;
        #1;
        chk("idle_wr_ready", 16'(wr_ready), 16'h1);

        // full clear, video off: one cell per clock
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        chk("clear_busy", 16'(busy), 16'h1);
        chk("clear_no_ready", 16'(wr_ready), 16'h0);
        wait_idle(n);
        chk("clear_cycles", 16'(n), 16'd2400);
        rd(0, 0, d);   chk("clear_0_0", 16'(d), 16'h20);
        rd(79, 29, d); chk("clear_79_29", 16'(d), 16'h20);
        rd(40, 15, d); chk("clear_40_15", 16'(d), 16'h20);
        tick(); tick();
        chk("hold_video_off", 16'(ascii_char), 16'h20);

        // 'A' at col 3 row 2, fetched at x=24 y=32 and held through x=31
        wr(3, 2, 8'h41);
        rd(3, 2, d);   chk("wr_A_fetch", 16'(d), 16'h41);
        video_on = 1'b1;
        for (int i = 25; i < 32; i++) begin
            x = 10'(i);
            tick();
        end
        chk("wr_A_held_x31", 16'(ascii_char), 16'h41);

        // write pressure during scan: ready only off fetch slots, fetches unaffected
        for (int i = 16; i < 32; i++) begin
            x = 10'(i); y = 10'd32; video_on = 1'b1;
            wr_valid = 1'b1; wr_col = 7'd5; wr_row = 5'd5; wr_char = 8'h5A;
            #1;
            chk($sformatf("scan_ready_x%0d", i), 16'(wr_ready), (i % 8 != 0) ? 16'h1 : 16'h0);
            tick();
            if (i % 8 == 0)
                chk($sformatf("scan_fetch_x%0d", i), 16'(ascii_char), (i == 24) ? 16'h41 : 16'h20);
        end
        wr_valid = 1'b0; video_on = 1'b0;
        rd(5, 5, d);   chk("scan_write_landed", 16'(d), 16'h5A);

        // out-of-range column: accepted, flagged, discarded
        video_on = 1'b0; wr_valid = 1'b1; wr_col = 7'd80; wr_row = 5'd0; wr_char = 8'h51;
        #1;
        chk("oor_ready", 16'(wr_ready), 16'h1);
        tick();
        wr_valid = 1'b0;
        chk("oor_err_pulse", 16'(wr_err), 16'h1);
        tick();
        chk("oor_err_clear", 16'(wr_err), 16'h0);
        rd(0, 1, d);   chk("oor_no_alias", 16'(d), 16'h20);

        // scroll: row r holds 0x30+r, then shifts up and row 29 blanks
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 80; c++)
                wr(c, r, 8'(8'h30 + r));
        rd(79, 29, d); chk("fill_79_29", 16'(d), 16'h4D);
        scroll_req = 1'b1;
        tick();
        scroll_req = 1'b0;
        chk("scroll_busy", 16'(busy), 16'h1);
        wait_idle(n);
        chk("scroll_cycles", 16'(n), 16'd4720);
        rd(0, 0, d);   chk("scroll_0_0", 16'(d), 16'h31);
        rd(79, 0, d);  chk("scroll_79_0", 16'(d), 16'h31);
        rd(40, 1, d);  chk("scroll_40_1", 16'(d), 16'h32);
        rd(0, 14, d);  chk("scroll_0_14", 16'(d), 16'h3F);
        rd(79, 28, d); chk("scroll_79_28", 16'(d), 16'h4D);
        rd(0, 29, d);  chk("scroll_0_29", 16'(d), 16'h20);
        rd(79, 29, d); chk("scroll_79_29", 16'(d), 16'h20);

        // clear beats scroll; reset after 100 cleared cells aborts
        clear_req = 1'b1; scroll_req = 1'b1;
        tick();
        clear_req = 1'b0; scroll_req = 1'b0;
        chk("both_busy", 16'(busy), 16'h1);
        for (int i = 0; i < 100; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("abort_busy", 16'(busy), 16'h0);
        chk("abort_ready", 16'(wr_ready), 16'h1);
        chk("abort_ascii", 16'(ascii_char), 16'h00);
        tick(); tick(); tick();
        chk("scroll_dropped", 16'(busy), 16'h0);
        rd(0, 0, d);   chk("abort_addr0", 16'(d), 16'h20);
        rd(19, 1, d);  chk("abort_addr99", 16'(d), 16'h20);
        rd(20, 1, d);  chk("abort_addr100", 16'(d), 16'h32);
        rd(0, 2, d);   chk("abort_addr160", 16'(d), 16'h33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
